// File: rtl/bpsk_frame_pkg.sv
// Shared definitions for the BPSK framer and the matching receive deframer.
package bpsk_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SYNC,
    ST_LEN,
    ST_PAYLOAD
  } tx_frame_state_t;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hD391;
  localparam int          SYNC_BITS_DEFAULT = 16;
  localparam int          LEN_BITS          = 8;

endpackage

// File: rtl/bpsk_tx_framer_if.sv
// Payload byte stream handshake between a byte source and the framer.
interface bpsk_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/bpsk_tx_framer_bit_timer.sv
// Free-running bit period counter; bit_tick marks the last clock of each bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Held at zero while disabled so the first bit of a frame gets a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (!en || cnt == LAST) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/bpsk_tx_framer.sv
// Frame serialiser feeding the BPSK modulator: preamble, sync, length, payload,
// MSB first, one bit per CLKS_PER_BIT clocks with no gaps inside a frame.
module bpsk_tx_framer
  import bpsk_frame_pkg::*;
#(
  parameter int                   CLKS_PER_BIT  = 20,
  parameter int                   PREAMBLE_BITS = 32,
  parameter int                   SYNC_BITS     = SYNC_BITS_DEFAULT,
  parameter logic [SYNC_BITS-1:0] SYNC_WORD     = SYNC_BITS'(SYNC_WORD_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             len,
  bpsk_tx_framer_if.slave        s,
  output logic                   bit_out,
  output logic                   bit_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   underrun
);

  localparam int SR_W  = (SYNC_BITS > LEN_BITS) ? SYNC_BITS : LEN_BITS;
  localparam int MAXF  = (PREAMBLE_BITS > SR_W) ? PREAMBLE_BITS : SR_W;
  localparam int CNT_W = $clog2(MAXF) + 1;

  tx_frame_state_t state, state_next;
  logic [CNT_W-1:0] bit_cnt, last_idx;
  logic [SR_W-1:0]  sr;
  logic [7:0]       len_q, byte_cnt, acc_cnt, buf_data;
  logic             buf_full, bit_tick, field_end;
  logic             done_set, under_set, load_sync, load_len, pop_buf;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (state != ST_IDLE),
    .bit_tick (bit_tick)
  );

  always_comb begin
    case (state)
      ST_PREAMBLE: last_idx = CNT_W'(PREAMBLE_BITS - 1);
      ST_SYNC:     last_idx = CNT_W'(SYNC_BITS - 1);
      default:     last_idx = CNT_W'(LEN_BITS - 1);
    endcase
  end

  assign field_end = bit_tick && (bit_cnt == last_idx);
  assign bit_valid = (state != ST_IDLE);
  assign busy      = (state != ST_IDLE);
  // Only registered terms, so an accepted byte lands the cycle after the handshake.
  assign s.s_ready = (state == ST_SYNC || state == ST_LEN || state == ST_PAYLOAD)
                     && !buf_full && (acc_cnt < len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_set   = 1'b0;
    under_set  = 1'b0;
    load_sync  = 1'b0;
    load_len   = 1'b0;
    pop_buf    = 1'b0;
    case (state)
      ST_IDLE:     if (start) state_next = ST_PREAMBLE;
      ST_PREAMBLE: if (field_end) begin state_next = ST_SYNC; load_sync = 1'b1; end
      ST_SYNC:     if (field_end) begin state_next = ST_LEN;  load_len  = 1'b1; end
      ST_LEN, ST_PAYLOAD: begin
        if (field_end) begin
          if ((state == ST_LEN && len_q == 8'd0) ||
              (state == ST_PAYLOAD && byte_cnt == len_q)) begin
            state_next = ST_IDLE;
            done_set   = 1'b1;
          end else if (buf_full) begin
            state_next = ST_PAYLOAD;
            pop_buf    = 1'b1;
          end else begin
            state_next = ST_IDLE;
            under_set  = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done     <= 1'b0;
      underrun <= 1'b0;
      bit_out  <= 1'b0;
      bit_cnt  <= '0;
      sr       <= '0;
      len_q    <= '0;
      byte_cnt <= '0;
    end else begin
      done     <= done_set;
      underrun <= under_set;
      if (state == ST_IDLE) begin
        bit_out <= start;
        bit_cnt <= '0;
        if (start) begin
          len_q    <= len;
          byte_cnt <= '0;
        end
      end else if (state_next == ST_IDLE) begin
        bit_out <= 1'b0;
      end else if (load_sync) begin
        sr      <= SR_W'(SYNC_WORD) << (SR_W - SYNC_BITS);
        bit_out <= SYNC_WORD[SYNC_BITS-1];
        bit_cnt <= '0;
      end else if (load_len) begin
        sr      <= SR_W'(len_q) << (SR_W - LEN_BITS);
        bit_out <= len_q[7];
        bit_cnt <= '0;
      end else if (pop_buf) begin
        sr       <= SR_W'(buf_data) << (SR_W - LEN_BITS);
        bit_out  <= buf_data[7];
        bit_cnt  <= '0;
        byte_cnt <= byte_cnt + 8'd1;
      end else if (bit_tick) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (state == ST_PREAMBLE) begin
          bit_out <= ~bit_out;
        end else begin
          sr      <= sr << 1;
          bit_out <= sr[SR_W-2];
        end
      end
    end
  end

  // Holding buffer: pop at a payload byte boundary and fill never coincide,
  // because filling requires it empty and popping requires it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      acc_cnt  <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        buf_full <= 1'b0;
        acc_cnt  <= '0;
      end
    end else begin
      if (pop_buf) buf_full <= 1'b0;
      if (s.s_valid && s.s_ready) begin
        buf_data <= s.s_data;
        buf_full <= 1'b1;
        acc_cnt  <= acc_cnt + 8'd1;
      end
    end
  end

endmodule
